servant_btn_debounce: RTL
=========================

# servant_btn_debounce

Input-conditioning stage directly upstream of the servant GPIO peripheral's button inputs. It synchronises the raw, asynchronous board push-buttons into the Wishbone clock domain and debounces each one against a shared sample tick. It drives the clean level that the GPIO read-back word carries, plus one-cycle press/release pulses for future interrupt or event logic.

## Interface
- `N_BTN`, default 3: number of buttons; must be ≥1.
- `TICK_DIV`, default 1000: clock cycles per sample tick; must be ≥1.
- `STABLE_TICKS`, default 16: consecutive mismatching ticks required to accept a new level; must be ≥1.
- `i_wb_clk`, in, 1: the single clock; all state is rising-edge.
- `i_wb_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_btn_raw`, in, N_BTN: raw pad levels, asynchronous, active-high (1 = pressed).
- `o_btn`, out, N_BTN: debounced level, registered; connects to the GPIO `buttons` input.
- `o_press`, out, N_BTN: one-cycle pulse when `o_btn[i]` goes 0→1.
- `o_release`, out, N_BTN: one-cycle pulse when `o_btn[i]` goes 1→0.
- `o_tick`, out, 1: the prescaler tick, exposed for observation.

## Operation
- **Synchroniser:** two flops per bit (`sync1`, `sync2`). Only `sync2` is used downstream.
- **Prescaler:**
  - Counter `pre` has width max(1, $clog2(TICK_DIV)).
  - `tick = (pre == TICK_DIV-1)`, combinational from `pre`.
  - `pre` wraps to 0 on tick, otherwise increments.
  - With TICK_DIV=1, `tick` is constantly 1.
- **Per channel:**
  - Stable counter `cnt` has width max(1, $clog2(STABLE_TICKS)).
  - `mismatch = sync2 != o_btn`.
  - If `!mismatch`, `cnt` ← 0 on that cycle, regardless of tick.
  - If `mismatch & tick & cnt == STABLE_TICKS-1`: commit. `o_btn` ← `sync2`, `cnt` ← 0, and the matching pulse is asserted next cycle (same edge as `o_btn` update).
  - Else if `mismatch & tick`, `cnt` ← `cnt`+1.
  - Otherwise hold.
- **Pulses:** `o_press` and `o_release` are registered.
  - `o_press[i] = 1` exactly in the first cycle that `o_btn[i]` reads 1 after being 0.
  - `o_release[i]` is the same for 1→0.
  - Both are 0 in every other cycle.
  - `o_press[i]` and `o_release[i]` are never both 1.
- **Independence:** channels are independent. Simultaneous commits on several channels are all honoured in the same cycle.
- **Glitch rejection:** any single-cycle match of `sync2` to `o_btn` restarts that channel's count.

## Timing
- **Reset values:** `sync1`, `sync2`, `pre`, all `cnt`, `o_btn`, `o_press` and `o_release` are 0. `o_tick` is 0 unless TICK_DIV=1.
- **Synchroniser latency:** `i_btn_raw` to `sync2` is 2 cycles.
- **Debounce latency:** from `sync2` changing (held stable) to the `o_btn` update, minimum (STABLE_TICKS-1)·TICK_DIV+1 cycles, maximum STABLE_TICKS·TICK_DIV cycles, depending on prescaler phase.
- **Prescaler phase:** the first tick after reset release is in the cycle where `pre` = TICK_DIV-1, i.e. the TICK_DIV-th clock edge after release. The prescaler runs freely and is never restarted by input activity.
- **Reset mid-debounce:** discards partial counts. `o_btn` returns to 0 with no pulse. A button held through reset re-qualifies as a fresh press.
- **Counter saturation:** `cnt` never exceeds STABLE_TICKS-1; no wrap is possible.

## Structure
- **Package `servant_btn_pkg`:** default constants for `TICK_DIV` and `STABLE_TICKS`, and a width helper function for the counters.
- **Sub-module `servant_debounce_ch`:** one channel (sync flops, `cnt`, `o_btn` bit, pulse bits), taking `tick` as input. It is instantiated N_BTN times via generate.
- **Top level:** holds the prescaler and the generate loop.

## Test plan
All scenarios use TICK_DIV=4, STABLE_TICKS=3.
- **Reset:** hold `i_wb_rst_n`=0 with `i_btn_raw`=3'b111 → all outputs 0. Assert reset mid-count → `o_btn` and `cnt` return to 0 immediately, with no pulse.
- **Clean press:** raise `i_btn_raw[0]` and hold → `o_btn[0]` rises 9–12 cycles after `sync2` rises, `o_press[0]` is high for exactly 1 cycle, and `o_release` stays 0.
- **Bounce:** toggle `i_btn_raw[1]` every 5 cycles for 40 cycles → `o_btn[1]` stays 0 and no pulses occur. Then hold 1 → accepted with the clean-press latency.
- **Release:** after the clean press, drop `i_btn_raw[0]` → `o_btn[0]` falls after 9–12 cycles, with one `o_release[0]` pulse.
- **Simultaneous:** raise all three raw bits on the same cycle → all `o_btn` bits and all `o_press` bits assert on the same cycle.
- **TICK_DIV=1, STABLE_TICKS=1:** raw rise → `o_btn` rises 3 cycles after the raw edge. `o_tick` is constantly 1 after reset.

Source files
------------

// File: rtl/servant_btn_pkg.sv
// servant_btn_pkg
//   Shared constants and helpers for the button debounce block.
//   DEF_TICK_DIV     : default clock cycles per debounce sample tick
//   DEF_STABLE_TICKS : default consecutive mismatching ticks needed to accept
//   cnt_width()      : counter width for a modulus n, never less than 1 bit
package servant_btn_pkg;

  localparam int unsigned DEF_TICK_DIV     = 1000;
  localparam int unsigned DEF_STABLE_TICKS = 16;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/servant_debounce_ch.sv
// servant_debounce_ch
//   One button channel: two-flop synchroniser, tick-qualified stable counter,
//   debounced level and one-cycle press/release pulses.
//   i_wb_clk    : clock, rising edge
//   i_wb_rst_n  : asynchronous active-low reset
//   i_tick      : shared sample tick from the prescaler
//   i_btn_raw   : raw asynchronous pad level (1 = pressed)
//   o_btn       : debounced level
//   o_press     : one-cycle pulse on o_btn 0->1
//   o_release   : one-cycle pulse on o_btn 1->0
module servant_debounce_ch
  import servant_btn_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic i_wb_clk,
  input  logic i_wb_rst_n,
  input  logic i_tick,
  input  logic i_btn_raw,
  output logic o_btn,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned CW = cnt_width(STABLE_TICKS);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          mismatch;
  logic          commit;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_btn_raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    mismatch = (sync2 != o_btn);
    commit   = mismatch && i_tick && (cnt == CW'(STABLE_TICKS - 1));
  end

  // Any cycle where the synchronised level agrees with o_btn restarts the
  // count, so a single-cycle glitch back to the old level costs a full
  // requalification. cnt stops at STABLE_TICKS-1 because that tick commits.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      cnt <= '0;
    end else if (!mismatch || commit) begin
      cnt <= '0;
    end else if (i_tick) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Pulses are written on the same edge as o_btn, so each is high exactly in
  // the first cycle the new level is visible.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_btn     <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      o_press   <= commit &&  sync2;
      o_release <= commit && !sync2;
      if (commit) begin
        o_btn <= sync2;
      end
    end
  end

endmodule

// File: rtl/servant_btn_debounce.sv
// servant_btn_debounce
//   Synchronises and debounces the board push-buttons for the GPIO block.
//   i_wb_clk    : clock, rising edge
//   i_wb_rst_n  : asynchronous active-low reset
//   i_btn_raw   : raw asynchronous pad levels, N_BTN bits (1 = pressed)
//   o_btn       : debounced levels, registered
//   o_press     : one-cycle pulse per bit on o_btn 0->1
//   o_release   : one-cycle pulse per bit on o_btn 1->0
//   o_tick      : free-running prescaler tick, one cycle every TICK_DIV
module servant_btn_debounce
  import servant_btn_pkg::*;
#(
  parameter int unsigned N_BTN        = 3,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst_n,
  input  logic [N_BTN-1:0] i_btn_raw,
  output logic [N_BTN-1:0] o_btn,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic             o_tick
);

  localparam int unsigned PW = cnt_width(TICK_DIV);

  logic [PW-1:0] pre;
  logic          tick;

  // With TICK_DIV=1 pre is pinned at 0 and tick is permanently high.
  always_comb begin
    tick = (pre == PW'(TICK_DIV - 1));
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  assign o_tick = tick;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    servant_debounce_ch #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .i_wb_clk  (i_wb_clk),
      .i_wb_rst_n(i_wb_rst_n),
      .i_tick    (tick),
      .i_btn_raw (i_btn_raw[g]),
      .o_btn     (o_btn[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g])
    );
  end

endmodule
